fetch_queue: RTL and testbench

- Instruction-fetch front end sitting directly upstream of the pipeline's IF/ID register.
- Issues in-order requests to an instruction memory with variable latency and buffers the returned words with their PCs in a small prefetch FIFO.
- Presents one instruction per cycle to decode.
- Honours decode stalls and branch/jump redirects, and discards stale in-flight responses after a redirect.

---
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited in-order requests to imem, prefetch FIFO
// of {pc, instr} toward decode, redirect flush with drop-counting of stale responses.
module fetch_queue #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [PC_W-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [INS_W-1:0]         imem_rsp_data,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [PC_W-1:0]          if_pc,
  output logic [INS_W-1:0]         if_instr,
  output logic [$clog2(DEPTH):0]   inflight
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, inf_q, drop_cnt;
  logic [PC_W-1:0] fetch_pc, rsp_pc, tgt;
  logic [CW:0]     credit_used;
  logic            empty, req_fire, rsp_acc, push, pop;

  assign tgt         = redirect_pc & ~PC_W'(3);
  assign empty       = (count == '0);
  assign credit_used = {1'b0, count} + {1'b0, inf_q};

  // Entries already buffered plus words still owed by memory may never exceed DEPTH,
  // so every accepted response always has a free FIFO slot.
  assign imem_req_valid = reset && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_acc = imem_rsp_valid && (inf_q != '0);
  assign push    = rsp_acc && (drop_cnt == '0) && !redirect;

  assign if_valid = !empty && !redirect;
  assign if_pc    = empty ? '0 : mem[rd_ptr].pc;
  assign if_instr = empty ? '0 : mem[rd_ptr].instr;
  assign pop      = if_valid && if_ready;
  assign inflight = inf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= '0;
      rsp_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inf_q    <= '0;
      drop_cnt <= '0;
    end else begin
      inf_q <= inf_q + CW'(req_fire) - CW'(rsp_acc);
      if (redirect) begin
        fetch_pc <= tgt;
        rsp_pc   <= tgt;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        // Everything still owed by memory predates the redirect and must be discarded.
        drop_cnt <= inf_q - CW'(rsp_acc);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_W'(4);
        if (rsp_acc && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + PC_W'(4);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: rsp_pc, instr: imem_rsp_data};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table for reset/stream/stall/redirect/reset
// corners, plus memory-model sequences for long-latency redirect and PC wrap.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [8:0]  imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [8:0]  if_pc;
  logic [31:0] if_instr;
  logic [2:0]  inflight;

  fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .inflight(inflight)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] w(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst, rd, rdy, mrdy, rv;
    logic [8:0] rpc, raddr;
    logic       erv, ev, eh;
    logic [8:0] ea, epc;
    logic [2:0] einf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, rd, input logic [8:0] rpc, input logic rdy, mrdy, rv,
                              input logic [8:0] raddr, input logic erv, input logic [8:0] ea,
                              input logic ev, eh, input logic [8:0] epc, input logic [2:0] einf);
    vec_t v;
    v.rst = rst; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.mrdy = mrdy; v.rv = rv; v.raddr = raddr;
    v.erv = erv; v.ea = ea; v.ev = ev; v.eh = eh; v.epc = epc; v.einf = einf;
    return v;
  endfunction

  // Memory model for the sequence tests: in-order, fixed latency.
  typedef struct {logic [8:0] a; int due;} mreq_t;
  mreq_t      mq[$];
  int         cyc = 0;
  int         lat = 1;
  int         pops = 0;
  logic [8:0] exp_pc = '0;

  task automatic cycle();
    mreq_t m;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = w(mq[0].a);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      m.a = imem_req_addr; m.due = cyc + lat;
      mq.push_back(m);
    end
    chk("inflight_le_depth", 32'(inflight <= 3'd4), 32'd1);
    if (redirect) begin
      chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
      chk("redir_if_valid", 32'(if_valid), 32'd0);
    end
    if (if_valid && if_ready) begin
      chk("pop_pc", 32'(if_pc), 32'(exp_pc));
      chk("pop_instr", if_instr, w(exp_pc));
      exp_pc = exp_pc + 9'd4;
      pops++;
    end
    @(posedge clk); @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
    mq.delete();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    cyc = 0; pops = 0; exp_pc = '0;
  endtask

  task automatic redir(input logic [8:0] pc);
    redirect = 1'b1; redirect_pc = pc;
    cycle();
    redirect = 1'b0; redirect_pc = '0;
    exp_pc = pc & 9'h1FC;
  endtask

  initial begin
    //          rst rd rpc    rdy mrdy rv raddr   erv ea     ev eh epc    inf
    vecs.push_back(mk(0, 0, 9'h0,  1, 1, 0, 9'h0,  0, 9'h0,  0, 0, 9'h0,  0));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 0, 9'h0,  1, 9'h0,  0, 0, 9'h0,  0));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 1, 9'h0,  1, 9'h4,  0, 0, 9'h0,  1));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 1, 9'h4,  1, 9'h8,  1, 1, 9'h0,  1));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 1, 9'h8,  1, 9'hC,  1, 1, 9'h4,  1));
    // decode stalls: FIFO fills until the credit limit closes issue
    vecs.push_back(mk(1, 0, 9'h0,  0, 1, 1, 9'hC,  1, 9'h10, 1, 1, 9'h8,  1));
    vecs.push_back(mk(1, 0, 9'h0,  0, 1, 1, 9'h10, 1, 9'h14, 1, 1, 9'h8,  1));
    vecs.push_back(mk(1, 0, 9'h0,  0, 1, 1, 9'h14, 0, 9'h18, 1, 1, 9'h8,  1));
    vecs.push_back(mk(1, 0, 9'h0,  0, 1, 0, 9'h0,  0, 9'h18, 1, 1, 9'h8,  0));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 0, 9'h0,  0, 9'h18, 1, 1, 9'h8,  0));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 0, 9'h0,  1, 9'h18, 1, 1, 9'hC,  0));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 1, 9'h18, 1, 9'h1C, 1, 1, 9'h10, 1));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 1, 9'h1C, 1, 9'h20, 1, 1, 9'h14, 1));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 0, 9'h0,  1, 9'h24, 1, 1, 9'h18, 1));
    // redirect coincident with a response, inflight=2: held entry hidden, one stale word dropped
    vecs.push_back(mk(1, 1, 9'h83, 1, 1, 1, 9'h20, 0, 9'h28, 0, 1, 9'h1C, 2));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 1, 9'h24, 1, 9'h80, 0, 0, 9'h0,  1));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 1, 9'h80, 1, 9'h84, 0, 0, 9'h0,  1));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 1, 9'h84, 1, 9'h88, 1, 1, 9'h80, 1));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 1, 9'h88, 1, 9'h8C, 1, 1, 9'h84, 1));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 0, 9'h0,  1, 9'h90, 1, 1, 9'h88, 1));
    // reset with 2 in flight; stale words after release must be ignored
    vecs.push_back(mk(0, 0, 9'h0,  1, 1, 0, 9'h0,  0, 9'h0,  0, 0, 9'h0,  0));
    vecs.push_back(mk(1, 0, 9'h0,  1, 0, 1, 9'h8C, 1, 9'h0,  0, 0, 9'h0,  0));
    vecs.push_back(mk(1, 0, 9'h0,  1, 0, 1, 9'h90, 1, 9'h0,  0, 0, 9'h0,  0));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 0, 9'h0,  1, 9'h0,  0, 0, 9'h0,  0));
    vecs.push_back(mk(1, 0, 9'h0,  1, 1, 1, 9'h0,  1, 9'h4,  0, 0, 9'h0,  1));
    vecs.push_back(mk(1, 0, 9'h0,  1, 0, 1, 9'h4,  1, 9'h8,  1, 1, 9'h0,  1));
    vecs.push_back(mk(1, 0, 9'h0,  1, 0, 0, 9'h0,  1, 9'h8,  1, 1, 9'h4,  0));
    vecs.push_back(mk(1, 0, 9'h0,  1, 0, 0, 9'h0,  1, 9'h8,  0, 0, 9'h0,  0));

    @(negedge clk);
    foreach (vecs[i]) begin
      reset          = vecs[i].rst;
      redirect       = vecs[i].rd;
      redirect_pc    = vecs[i].rpc;
      if_ready       = vecs[i].rdy;
      imem_req_ready = vecs[i].mrdy;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data  = vecs[i].rv ? w(vecs[i].raddr) : 32'd0;
      #1;
      chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].erv));
      chk($sformatf("v%0d_req_addr", i), 32'(imem_req_addr), 32'(vecs[i].ea));
      chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d_if_pc", i), 32'(if_pc), vecs[i].eh ? 32'(vecs[i].epc) : 32'd0);
      chk($sformatf("v%0d_if_instr", i), if_instr, vecs[i].eh ? w(vecs[i].epc) : 32'd0);
      chk($sformatf("v%0d_inflight", i), 32'(inflight), 32'(vecs[i].einf));
      @(posedge clk); @(negedge clk);
    end
    redirect = 1'b0; imem_rsp_valid = 1'b0;

    // Long latency: three words owed at redirect, all three must be discarded.
    do_reset();
    lat = 4;
    for (int i = 0; i < 20 && inflight != 3'd3; i++) cycle();
    chk("seq3_inflight_before_redir", 32'(inflight), 32'd3);
    redir(9'h040);
    for (int i = 0; i < 16; i++) cycle();
    chk("seq3_pops_after_redir", 32'(pops >= 4), 32'd1);

    // Redirect near the top of the address space wraps to 0.
    do_reset();
    lat = 1;
    for (int i = 0; i < 5; i++) cycle();
    redir(9'h1FB);
    pops = 0;
    for (int i = 0; i < 10; i++) cycle();
    chk("seq5_pops_after_wrap", 32'(pops >= 4), 32'd1);
    chk("seq5_exp_pc_wrapped", 32'(exp_pc < 9'h1F8), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
